// File: rtl/rx_fifo.sv
// rx_fifo: receive-side byte buffer sitting directly behind the UART receiver.
// Captures each byte the receiver flags as available, acknowledges it with a
// one-cycle over_read pulse, and offers the bytes to the bus side through a
// show-ahead pop interface with a sticky overflow flag.
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          rx_over_read,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             capture;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [AW:0]      count_next;

    // Decide what happens to the FIFO this cycle: a capture from the receiver,
    // a bus-side pop, and whether the captured byte fits or must be dropped.
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // byte when it is being read at the same time.
    always_comb begin
        capture    = (state == IDLE) && rx_rs;
        pop        = rd_en && !empty;
        push_ok    = capture && (!full || pop);
        drop       = capture && full && !pop;
        count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end

    // Capture handshake with the receiver: one capture per rx_rs assertion,
    // a single over_read pulse, then wait for rx_rs to fall before re-arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rx_over_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_rs) begin
                        state        <= ACK;
                        rx_over_read <= 1'b1;
                    end else begin
                        rx_over_read <= 1'b0;
                    end
                end
                ACK: begin
                    state        <= WAIT_LOW;
                    rx_over_read <= 1'b0;
                end
                WAIT_LOW: begin
                    rx_over_read <= 1'b0;
                    if (!rx_rs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rx_over_read <= 1'b0;
                end
            endcase
        end
    end

    // Pointers, occupancy and status flags; flags are registered from the
    // next occupancy so they line up with the count they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Byte storage; deliberately left unreset since the pointers define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Show-ahead head entry, forced to zero when nothing is held.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule
